// File: rtl/dev_bus_slave.sv
// -----------------------------------------------------------------------------
// dev_bus_slave
//   Target that sits behind the 4-host round-robin device-bus arbiter.
//   Every access is decoded to one of three targets:
//     - local register bank (NREG x DW).
//       reg0 is CTRL and is writable by CPU hosts only.
//       reg NREG-1 is STATUS: sticky error bits plus a timeout counter.
//     - external peripheral port, with a req/ack handshake and a timeout.
//     - error responder, for unmapped addresses and for rd+wr together.
//
// Handshake (upstream side): the host raises rd_bus or wr_bus and holds it,
//   with address and data stable, until it sees ack_bus. ack_bus is a
//   one-cycle pulse, and data_bus_rd is valid only in that cycle. If the
//   strobe falls before ack_bus, the access is abandoned and no ack is sent.
//   Downstream side: ext_req is held until the first cycle in which ext_ack
//   is seen. ext_rdata is valid with ext_ack.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   add_bus, byte_en          access address and write byte enables
//   wr_bus, rd_bus            write / read strobes
//   data_bus_wr, cpu_bus      write data, CPU-host privilege qualifier
//   data_bus_rd, ack_bus      read data, completion pulse
//   ext_req/we/addr/be/wdata  external request channel
//   ext_rdata, ext_ack        external response channel
//   irq_err                   OR of the sticky STATUS error bits
// -----------------------------------------------------------------------------
module dev_bus_slave #(
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter int              BW       = 4,
   parameter int              WIN_BITS = 16,
   parameter int              LOC_BASE = 'h0000,
   parameter int              EXT_BASE = 'h0001,
   parameter int              NREG     = 16,
   parameter int              LOC_WAIT = 1,
   parameter int              EXT_TO   = 255,
   parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [AW-1:0]       add_bus,
   input  logic [BW-1:0]       byte_en,
   input  logic                wr_bus,
   input  logic                rd_bus,
   input  logic [DW-1:0]       data_bus_wr,
   input  logic                cpu_bus,
   output logic [DW-1:0]       data_bus_rd,
   output logic                ack_bus,
   output logic                ext_req,
   output logic                ext_we,
   output logic [WIN_BITS-1:0] ext_addr,
   output logic [BW-1:0]       ext_be,
   output logic [DW-1:0]       ext_wdata,
   input  logic [DW-1:0]       ext_rdata,
   input  logic                ext_ack,
   output logic                irq_err
);

   localparam int UW = AW - WIN_BITS;
   localparam int IW = $clog2(NREG);
   localparam int TW = $clog2(EXT_TO + 1);
   localparam logic [UW-1:0] LOC_WIN   = UW'(LOC_BASE);
   localparam logic [UW-1:0] EXT_WIN   = UW'(EXT_BASE);
   localparam logic [IW-1:0] CTRL_IDX  = '0;
   localparam logic [IW-1:0] STAT_IDX  = IW'(NREG - 1);
   localparam logic [2:0]    WAIT_INIT = 3'(LOC_WAIT);
   // ext_req stays high for exactly EXT_TO cycles before the access errors out.
   localparam logic [TW-1:0] TO_LAST   = TW'(EXT_TO - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOC, S_EXT, S_EXT_ABORT, S_RESP} state_t;

   state_t          state_q;
   logic [2:0]      wait_q;
   logic [TW-1:0]   to_cnt_q;
   logic [DW-1:0]   regs_q [NREG];
   logic            sticky_to_q, sticky_err_q;
   logic [7:0]      to_count_q;
   logic            sticky_to_d, sticky_err_d;
   logic [7:0]      to_count_d;

   logic [DW-1:0]   data_bus_rd_q, ext_wdata_q;
   logic            ack_q, ext_req_q, ext_we_q, irq_q;
   logic [WIN_BITS-1:0] ext_addr_q;
   logic [BW-1:0]   ext_be_q;

   logic            strobe, in_loc, in_ext, illegal, loc_commit, to_expire;
   logic [IW-1:0]   idx;
   logic [DW-1:0]   status_rd, loc_rdata, wr_merged;

   assign strobe  = rd_bus | wr_bus;
   assign illegal = rd_bus & wr_bus;
   assign in_loc  = (add_bus[AW-1:WIN_BITS] == LOC_WIN);
   assign in_ext  = (add_bus[AW-1:WIN_BITS] == EXT_WIN);
   assign idx     = add_bus[IW+1:2];

   // Local write takes effect on the edge that moves LOC into RESP.
   assign loc_commit = (state_q == S_LOC) && strobe && (wait_q == '0) && wr_bus;
   // Timeout fires in EXT or EXT_ABORT only when no ext_ack arrives with it.
   assign to_expire  = ((state_q == S_EXT) || (state_q == S_EXT_ABORT)) &&
                       !ext_ack && (to_cnt_q == TO_LAST);

   assign status_rd = DW'({to_count_q, 6'b0, sticky_err_q, sticky_to_q});

   always_comb begin
      loc_rdata = (idx == STAT_IDX) ? status_rd : regs_q[idx];
      wr_merged = regs_q[idx];
      for (int b = 0; b < BW; b++) begin
         if (byte_en[b]) wr_merged[8*b +: 8] = data_bus_wr[8*b +: 8];
      end
   end

   // STATUS next state: W1C on bits[1:0] through byte lane 0, and a set
   // takes priority over a clear in the same cycle.
   always_comb begin
      logic clr_to, clr_err, set_err;
      clr_to      = loc_commit && (idx == STAT_IDX) && byte_en[0] && data_bus_wr[0];
      clr_err     = loc_commit && (idx == STAT_IDX) && byte_en[0] && data_bus_wr[1];
      set_err     = (state_q == S_IDLE) && strobe && (illegal || !(in_loc || in_ext));
      sticky_to_d  = to_expire | (sticky_to_q & ~clr_to);
      sticky_err_d = set_err | (sticky_err_q & ~clr_err);
      to_count_d   = (to_expire && (to_count_q != 8'hFF)) ? to_count_q + 8'd1 : to_count_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         wait_q        <= '0;
         to_cnt_q      <= '0;
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         sticky_to_q   <= 1'b0;
         sticky_err_q  <= 1'b0;
         to_count_q    <= '0;
         data_bus_rd_q <= '0;
         ack_q         <= 1'b0;
         ext_req_q     <= 1'b0;
         ext_we_q      <= 1'b0;
         ext_addr_q    <= '0;
         ext_be_q      <= '0;
         ext_wdata_q   <= '0;
         irq_q         <= 1'b0;
      end else begin
         // Response outputs are pulses; only the edge entering RESP sets them.
         ack_q         <= 1'b0;
         data_bus_rd_q <= '0;
         sticky_to_q   <= sticky_to_d;
         sticky_err_q  <= sticky_err_d;
         to_count_q    <= to_count_d;
         irq_q         <= sticky_to_d | sticky_err_d;

         case (state_q)
            S_IDLE: begin
               if (strobe) begin
                  if (illegal || !(in_loc || in_ext)) begin
                     state_q       <= S_RESP;
                     ack_q         <= 1'b1;
                     data_bus_rd_q <= ERR_DATA;
                  end else if (in_loc) begin
                     state_q <= S_LOC;
                     wait_q  <= WAIT_INIT;
                  end else begin
                     state_q     <= S_EXT;
                     ext_req_q   <= 1'b1;
                     ext_we_q    <= wr_bus;
                     ext_addr_q  <= add_bus[WIN_BITS-1:0];
                     ext_be_q    <= byte_en;
                     ext_wdata_q <= data_bus_wr;
                     to_cnt_q    <= '0;
                  end
               end
            end
            S_LOC: begin
               if (!strobe) begin
                  state_q <= S_IDLE;
               end else if (wait_q != '0) begin
                  wait_q <= wait_q - 3'd1;
               end else begin
                  state_q <= S_RESP;
                  ack_q   <= 1'b1;
                  if (wr_bus) begin
                     // CTRL ignores non-CPU writes; STATUS is handled above.
                     if ((idx != STAT_IDX) && ((idx != CTRL_IDX) || cpu_bus))
                        regs_q[idx] <= wr_merged;
                  end else begin
                     data_bus_rd_q <= loc_rdata;
                  end
               end
            end
            S_EXT, S_EXT_ABORT: begin
               if (ext_ack || to_expire) begin
                  ext_req_q <= 1'b0;
                  if ((state_q == S_EXT) && strobe) begin
                     state_q <= S_RESP;
                     ack_q   <= 1'b1;
                     if (!ext_ack)      data_bus_rd_q <= ERR_DATA;
                     else if (!ext_we_q) data_bus_rd_q <= ext_rdata;
                  end else begin
                     // Abandoned access: the response is discarded.
                     state_q <= S_IDLE;
                  end
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
                  if ((state_q == S_EXT) && !strobe) state_q <= S_EXT_ABORT;
               end
            end
            S_RESP: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign data_bus_rd = data_bus_rd_q;
   assign ack_bus     = ack_q;
   assign ext_req     = ext_req_q;
   assign ext_we      = ext_we_q;
   assign ext_addr    = ext_addr_q;
   assign ext_be      = ext_be_q;
   assign ext_wdata   = ext_wdata_q;
   assign irq_err     = irq_q;

endmodule

// File: tb/tb_dev_bus_slave.sv
// -----------------------------------------------------------------------------
// tb_dev_bus_slave
//   Directed bench for dev_bus_slave with default parameters. Inputs are
//   driven on the falling edge and outputs are sampled on the falling edge.
//   Latency is counted in rising edges after the strobe is driven: local = 3,
//   unmapped/illegal = 1, external = ext_delay + 1, timeout = EXT_TO + 1.
// -----------------------------------------------------------------------------
module tb_dev_bus_slave;

   logic        clk;
   logic        reset_n;
   logic [31:0] add_bus;
   logic [3:0]  byte_en;
   logic        wr_bus, rd_bus, cpu_bus;
   logic [31:0] data_bus_wr, data_bus_rd;
   logic        ack_bus;
   logic        ext_req, ext_we, ext_ack, irq_err;
   logic [15:0] ext_addr;
   logic [3:0]  ext_be;
   logic [31:0] ext_wdata, ext_rdata;

   int checks   = 0;
   int failures = 0;

   // Results of the last bus_access call.
   int          lat, req_cycles;
   logic [31:0] rdata_seen, post_data, seen_wdata;
   logic        req_at_ack, irq_at_ack, post_ack, seen_we;
   logic [15:0] seen_addr;
   logic [3:0]  seen_be;

   dev_bus_slave dut (
      .clk(clk), .reset_n(reset_n), .add_bus(add_bus), .byte_en(byte_en),
      .wr_bus(wr_bus), .rd_bus(rd_bus), .data_bus_wr(data_bus_wr),
      .cpu_bus(cpu_bus), .data_bus_rd(data_bus_rd), .ack_bus(ack_bus),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
      .ext_be(ext_be), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
      .ext_ack(ext_ack), .irq_err(irq_err)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- checker ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Runs one access to completion. Acts as the external responder too:
   // pulses ext_ack after ext_req has been seen for ext_delay cycles
   // (ext_delay < 0 means never respond).
   task automatic bus_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata,
                             input logic cpu, input int ext_delay);
      int reqs;
      @(negedge clk);
      rd_bus = rd; wr_bus = wr; add_bus = addr; byte_en = be;
      data_bus_wr = wdata; cpu_bus = cpu;
      lat = 0; reqs = 0; rdata_seen = '0; req_at_ack = 1'b0; irq_at_ack = 1'b0;
      for (int k = 1; k <= 400 && lat == 0; k++) begin
         @(negedge clk);
         if (ack_bus) begin
            lat        = k;
            rdata_seen = data_bus_rd;
            req_at_ack = ext_req;
            irq_at_ack = irq_err;
         end else begin
            ext_ack = 1'b0;
            if (ext_req) begin
               reqs++;
               if (reqs == 1) begin
                  seen_addr = ext_addr; seen_we = ext_we;
                  seen_be = ext_be; seen_wdata = ext_wdata;
               end
               if (reqs == ext_delay) ext_ack = 1'b1;
            end
         end
      end
      ext_ack = 1'b0; rd_bus = 1'b0; wr_bus = 1'b0;
      req_cycles = reqs;
      @(negedge clk);
      post_ack  = ack_bus;
      post_data = data_bus_rd;
   endtask

   task automatic read_reg(input logic [31:0] addr, input string tag, input logic [31:0] exp);
      bus_access(1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b1, -1);
      check_val({tag, "_lat"}, lat, 3);
      check_val(tag, rdata_seen, exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acks, reqs;
      reset_n = 1'b0; add_bus = '0; byte_en = '0; wr_bus = 1'b0; rd_bus = 1'b0;
      data_bus_wr = '0; cpu_bus = 1'b0; ext_rdata = '0; ext_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_ack", ack_bus, 0);
      check_val("rst_rdata", data_bus_rd, 0);
      check_val("rst_ext_req", ext_req, 0);
      check_val("rst_irq", irq_err, 0);
      reset_n = 1'b1;

      // Local byte-enabled write then read back.
      bus_access(1'b0, 1'b1, 32'h0000_0008, 4'b0101, 32'h1122_3344, 1'b1, -1);
      check_val("loc_wr_lat", lat, 3);
      check_val("loc_wr_rdata", rdata_seen, 0);
      read_reg(32'h0000_0008, "reg2_rd", 32'h0022_0044);
      check_val("reg2_post_ack", post_ack, 0);
      check_val("reg2_post_data", post_data, 0);
      // add_bus[1:0] ignored.
      read_reg(32'h0000_000B, "reg2_rd_lowbits", 32'h0022_0044);

      // CTRL protection.
      bus_access(1'b0, 1'b1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 1'b0, -1);
      check_val("ctrl_nocpu_lat", lat, 3);
      read_reg(32'h0000_0000, "ctrl_nocpu", 32'h0);
      bus_access(1'b0, 1'b1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 1'b1, -1);
      read_reg(32'h0000_0000, "ctrl_cpu", 32'hFFFF_FFFF);

      // External read and write.
      ext_rdata = 32'hCAFE_F00D;
      bus_access(1'b1, 1'b0, 32'h0001_0010, 4'h0, 32'h0, 1'b1, 5);
      check_val("ext_rd_lat", lat, 6);
      check_val("ext_rd_data", rdata_seen, 32'hCAFE_F00D);
      check_val("ext_rd_addr", seen_addr, 16'h0010);
      check_val("ext_rd_we", seen_we, 0);
      check_val("ext_rd_req_at_ack", req_at_ack, 0);
      check_val("ext_rd_post_data", post_data, 0);
      bus_access(1'b0, 1'b1, 32'h0001_0004, 4'b0011, 32'h0000_5A5A, 1'b0, 2);
      check_val("ext_wr_lat", lat, 3);
      check_val("ext_wr_rdata", rdata_seen, 0);
      check_val("ext_wr_we", seen_we, 1);
      check_val("ext_wr_be", seen_be, 4'b0011);
      check_val("ext_wr_wdata", seen_wdata, 32'h0000_5A5A);
      check_val("ext_wr_addr", seen_addr, 16'h0004);

      // External timeout.
      bus_access(1'b1, 1'b0, 32'h0001_0040, 4'h0, 32'h0, 1'b1, -1);
      check_val("to_lat", lat, 256);
      check_val("to_req_cycles", req_cycles, 255);
      check_val("to_data", rdata_seen, 32'hDEAD_BEEF);
      check_val("to_irq", irq_at_ack, 1);
      read_reg(32'h0000_003C, "to_status", 32'h0000_0101);
      bus_access(1'b0, 1'b1, 32'h0000_003C, 4'h1, 32'h0000_0001, 1'b1, -1);
      check_val("w1c_irq", irq_at_ack, 0);
      read_reg(32'h0000_003C, "w1c_status", 32'h0000_0100);

      // Unmapped and illegal.
      bus_access(1'b1, 1'b0, 32'h0005_0000, 4'h0, 32'h0, 1'b1, -1);
      check_val("unmap_lat", lat, 1);
      check_val("unmap_data", rdata_seen, 32'hDEAD_BEEF);
      check_val("unmap_irq", irq_at_ack, 1);
      read_reg(32'h0000_003C, "unmap_status", 32'h0000_0102);
      bus_access(1'b1, 1'b1, 32'h0000_000C, 4'hF, 32'h1234_5678, 1'b1, -1);
      check_val("illegal_lat", lat, 1);
      check_val("illegal_data", rdata_seen, 32'hDEAD_BEEF);
      read_reg(32'h0000_000C, "illegal_reg3", 32'h0);
      // W1C gated by byte_en[0]; upper STATUS bits read-only.
      bus_access(1'b0, 1'b1, 32'h0000_003C, 4'hE, 32'hFFFF_FF03, 1'b1, -1);
      read_reg(32'h0000_003C, "w1c_gated", 32'h0000_0102);
      bus_access(1'b0, 1'b1, 32'h0000_003C, 4'h1, 32'h0000_0002, 1'b1, -1);
      read_reg(32'h0000_003C, "w1c_bit1", 32'h0000_0100);

      // Abort in LOC: no write, no ack.
      @(negedge clk);
      wr_bus = 1'b1; add_bus = 32'h0000_0014; byte_en = 4'hF;
      data_bus_wr = 32'hA5A5_A5A5; cpu_bus = 1'b1;
      @(negedge clk);
      wr_bus = 1'b0;
      acks = 0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); acks += int'(ack_bus); end
      check_val("loc_abort_ack", acks, 0);
      read_reg(32'h0000_0014, "loc_abort_reg5", 32'h0);

      // Abort in EXT: ext_req held until ext_ack, no ack on the bus.
      @(negedge clk);
      rd_bus = 1'b1; add_bus = 32'h0001_0020;
      repeat (3) @(negedge clk);
      rd_bus = 1'b0;
      acks = 0; reqs = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); acks += int'(ack_bus); reqs += int'(ext_req);
      end
      check_val("ext_abort_req_held", reqs, 10);
      ext_ack = 1'b1; ext_rdata = 32'h1357_9BDF;
      @(negedge clk);
      ext_ack = 1'b0;
      check_val("ext_abort_req_drop", ext_req, 0);
      for (int i = 0; i < 4; i++) begin @(negedge clk); acks += int'(ack_bus); end
      check_val("ext_abort_ack", acks, 0);

      // Set an error bit, then reset in the middle of an external access.
      bus_access(1'b1, 1'b0, 32'h0007_0000, 4'h0, 32'h0, 1'b1, -1);
      check_val("unmap2_irq", irq_at_ack, 1);
      @(negedge clk);
      rd_bus = 1'b1; add_bus = 32'h0001_0030;
      repeat (2) @(negedge clk);
      check_val("rst_ext_pre_req", ext_req, 1);
      reset_n = 1'b0;
      #1;
      check_val("rst_ext_req", ext_req, 0);
      check_val("rst_ext_addr", ext_addr, 0);
      check_val("rst_ext_irq", irq_err, 0);
      check_val("rst_ext_ack", ack_bus, 0);
      @(negedge clk);
      rd_bus = 1'b0;
      reset_n = 1'b1;
      read_reg(32'h0000_003C, "rst_status", 32'h0);
      read_reg(32'h0000_0008, "rst_reg2", 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
